// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble).
// One iteration per clock: 14 CONVERT cycles per operand, done pulses once
// per completed conversion, overflow flags operands above 9999.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] op_q, op_d;
  logic [16:0] scr_q, scr_d;
  logic [16:0] adj;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  // Add-3 correction on every scratch nibble >= 5; bit 16 is at most 1 and never needs it
  always_comb begin
    adj = scr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state, datapath update and completion strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        scr_d = {adj[15:0], op_q[13]};
        op_d  = {op_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          // After the last shift a set bit 16 means the operand was >= 10000
          bcd_d   = scr_d[15:0];
          ovf_d   = scr_d[16];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == CONVERT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, corner-case
// sequences, back-to-back streaming and a random sweep against a
// decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // {overflow, bcd} from plain decimal arithmetic
  function automatic logic [16:0] ref_model(input int unsigned v);
    int unsigned m;
    m = v % 10000;
    return {(v > 9999) ? 1'b1 : 1'b0, 4'(m / 1000), 4'((m / 100) % 10),
            4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one conversion from IDLE and wait (bounded) for done; lat = edges after start edge
  task automatic run_conv(input logic [13:0] v, output int lat);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    else check("busy_with_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          pulses;
    int          edge_n;
    int          last_done;
    bit          cap_pending;
    logic [13:0] q[$];
    logic [13:0] v;
    logic [16:0] r;

    vecs[0]  = '{14'd0,     16'h0000, 1'b0};
    vecs[1]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[2]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[3]  = '{14'd10000, 16'h0000, 1'b1};
    vecs[4]  = '{14'd16383, 16'h6383, 1'b1};
    vecs[5]  = '{14'd5,     16'h0005, 1'b0};
    vecs[6]  = '{14'd9,     16'h0009, 1'b0};
    vecs[7]  = '{14'd10,    16'h0010, 1'b0};
    vecs[8]  = '{14'd99,    16'h0099, 1'b0};
    vecs[9]  = '{14'd8765,  16'h8765, 1'b0};
    vecs[10] = '{14'd10001, 16'h0001, 1'b1};
    vecs[11] = '{14'd8765,  16'h8765, 1'b0};

    // Reset asserted before any clock edge must clear outputs at once
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {16'd0, bcd}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Vector table, including latency, pulse width and hold checks
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, lat);
      check("tbl_latency", lat, 14);
      check("tbl_bcd", {16'd0, bcd}, {16'd0, vecs[i].exp_bcd});
      check("tbl_ovf", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      bin = 14'($urandom);
      tick();
      check("tbl_done_1cyc", {31'd0, done}, 32'd0);
      tick();
      check("tbl_bcd_hold", {16'd0, bcd}, {16'd0, vecs[i].exp_bcd});
      check("tbl_ovf_hold", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end

    // Start while busy is ignored and bin changes after capture have no effect
    bin   = 14'd42;
    start = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        start = 1'b1;
        bin   = 14'd777;
      end
      if (k == 9) start = 1'b0;
      tick();
      if (done) begin
        pulses++;
        check("ign_latency", k, 14);
        check("ign_bcd", {16'd0, bcd}, 32'h0042);
        check("ign_ovf", {31'd0, overflow}, 32'd0);
      end
    end
    check("ign_pulses", pulses, 1);

    // Asynchronous reset mid-conversion aborts with no done pulse
    bin   = 14'd5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #3 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_bcd", {16'd0, bcd}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_conv(14'd1234, lat);
    check("post_abort_lat", lat, 14);
    check("post_abort_bcd", {16'd0, bcd}, 32'h1234);

    // Start on the very first edge after reset release is accepted
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_conv(14'd16383, lat);
    check("first_edge_lat", lat, 14);
    check("first_edge_bcd", {16'd0, bcd}, 32'h6383);
    check("first_edge_ovf", {31'd0, overflow}, 32'd1);

    // start held high: captures happen at the first edge and the edge after each done
    start       = 1'b1;
    cap_pending = 1'b1;
    last_done   = -1;
    pulses      = 0;
    q.delete();
    for (edge_n = 0; edge_n < 100; edge_n++) begin
      v   = 14'($urandom);
      bin = v;
      tick();
      if (cap_pending) begin
        q.push_back(v);
        cap_pending = 1'b0;
      end
      if (done) begin
        pulses++;
        if (last_done < 0) check("b2b_first_lat", edge_n, 14);
        else check("b2b_spacing", edge_n - last_done, 15);
        last_done = edge_n;
        if (q.size() == 0) check("b2b_unexpected_done", 32'd1, 32'd0);
        else begin
          r = ref_model(q.pop_front());
          check("b2b_bcd", {16'd0, bcd}, {16'd0, r[15:0]});
          check("b2b_ovf", {31'd0, overflow}, {31'd0, r[16]});
        end
        cap_pending = 1'b1;
      end
    end
    start = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      tick();
      if (done) begin
        pulses++;
        r = ref_model(q.pop_front());
        check("b2b_drain_bcd", {16'd0, bcd}, {16'd0, r[15:0]});
        check("b2b_drain_ovf", {31'd0, overflow}, {31'd0, r[16]});
      end
    end
    check("b2b_queue_empty", q.size(), 0);
    check("b2b_pulses", pulses, 7);
    repeat (2) tick();

    // Random sweep plus the decimal boundaries against the reference model
    for (int k = 0; k < 305; k++) begin
      case (k)
        0: v = 14'd9998;
        1: v = 14'd9999;
        2: v = 14'd10000;
        3: v = 14'd10001;
        4: v = 14'd16383;
        default: v = 14'($urandom_range(16383, 0));
      endcase
      run_conv(v, lat);
      r = ref_model(v);
      check("rnd_lat", lat, 14);
      check("rnd_bcd", {16'd0, bcd}, {16'd0, r[15:0]});
      check("rnd_ovf", {31'd0, overflow}, {31'd0, r[16]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
